// File: rtl/lsu_memctl.sv
// rtl/lsu_memctl.sv - load/store unit front end for a single-port word RAM (macro LSU_MISALIGN_TRAP_EN)
module lsu_memctl #(
  parameter int RAM_WORDS = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic        ram_we,
  input  logic [31:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  localparam logic [31:0] RAM_LIMIT = 32'(RAM_WORDS);

  state_t      state;
  state_t      state_next;

  logic        accept;
  logic        range_err;
  logic        funct3_err;
  logic        is_half;
  logic        is_word;
  logic        fault_in;
  logic [1:0]  off_in;

  logic        we_q;
  logic [2:0]  funct3_q;
  logic [29:0] idx_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;
  logic        fault_q;

  logic [31:0] rdata_hold;
  logic        fault_hold;
  logic [31:0] store_word;
  logic [31:0] load_word;
  logic [31:0] done_rdata;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Request decode: range, size-code legality and (optionally) alignment of the incoming access
  always_comb begin
    accept    = req_valid && (state == IDLE);
    range_err = {2'b00, req_addr[31:2]} >= RAM_LIMIT;
    is_half   = (req_funct3[1:0] == 2'b01);
    is_word   = (req_funct3[1:0] == 2'b10);
    if (req_we) begin
      funct3_err = req_funct3[2] || (req_funct3[1:0] == 2'b11);
    end else begin
      funct3_err = (req_funct3[1:0] == 2'b11) || (req_funct3[2] && req_funct3[1]);
    end
`ifdef LSU_MISALIGN_TRAP_EN
    off_in   = req_addr[1:0];
    fault_in = range_err || funct3_err ||
               (is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00));
`else
    if (is_word) begin
      off_in = 2'b00;
    end else if (is_half) begin
      off_in = {req_addr[1], 1'b0};
    end else begin
      off_in = req_addr[1:0];
    end
    fault_in = range_err || funct3_err;
`endif
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: faults skip the RAM, SW writes directly, SB/SH read first
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (fault_in) begin
            state_next = DONE;
          end else if (req_we && (req_funct3 == 3'b010)) begin
            state_next = WR;
          end else begin
            state_next = RD;
          end
        end
      end
      RD:      state_next = we_q ? WR : DONE;
      WR:      state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Capture all request fields at acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      idx_q    <= 30'd0;
      off_q    <= 2'b00;
      wdata_q  <= 32'd0;
      fault_q  <= 1'b0;
    end else if (accept) begin
      we_q     <= req_we;
      funct3_q <= req_funct3;
      idx_q    <= req_addr[31:2];
      off_q    <= off_in;
      wdata_q  <= req_wdata;
      fault_q  <= fault_in;
    end
  end

  // Data path: merge store data into the old word, extract/extend load data
  always_comb begin
    store_word = ram_rdata;
    case (funct3_q[1:0])
      2'b00:   store_word[{off_q, 3'b000} +: 8]       = wdata_q[7:0];
      2'b01:   store_word[{off_q[1], 4'b0000} +: 16]  = wdata_q[15:0];
      default: store_word = wdata_q;
    endcase
    sel_byte = ram_rdata[{off_q, 3'b000} +: 8];
    sel_half = ram_rdata[{off_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  load_word = {{24{sel_byte[7]}}, sel_byte};
      3'b001:  load_word = {{16{sel_half[15]}}, sel_half};
      3'b010:  load_word = ram_rdata;
      3'b100:  load_word = {24'd0, sel_byte};
      3'b101:  load_word = {16'd0, sel_half};
      default: load_word = 32'd0;
    endcase
    done_rdata = (fault_q || we_q) ? 32'd0 : load_word;
  end

  // Response hold registers keep the last DONE result visible until the next one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_hold <= 32'd0;
      fault_hold <= 1'b0;
    end else if (state == DONE) begin
      rdata_hold <= done_rdata;
      fault_hold <= fault_q;
    end
  end

  // Outputs decoded from state so reset clears them immediately
  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == DONE);
    resp_rdata = (state == DONE) ? done_rdata : rdata_hold;
    resp_fault = (state == DONE) ? fault_q : fault_hold;
    ram_we     = (state == WR);
    ram_wdata  = (state == WR) ? store_word : 32'd0;
    if ((state == RD) || (state == WR) || ((state == DONE) && !fault_q)) begin
      ram_addr = {2'b00, idx_q};
    end else begin
      ram_addr = 32'd0;
    end
  end

endmodule

// File: tb/tb_lsu_memctl.sv
// tb/tb_lsu_memctl.sv - randomized self-checking bench for lsu_memctl against a word-array model
module tb_lsu_memctl;

  localparam int WORDS = 128;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_we;
  logic [31:0] ram_rdata;

  logic [31:0] mem     [0:WORDS-1];
  logic [31:0] ref_mem [0:WORDS-1];

  int          n_tests;
  int          n_fail;
  int          we_cnt;
  logic [31:0] we_addr;
  logic [31:0] obs_rd;

  lsu_memctl #(.RAM_WORDS(WORDS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_fault (resp_fault),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_we     (ram_we),
    .ram_rdata  (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM: registered read of the presented word, write on ram_we
  initial begin
    for (int i = 0; i < WORDS; i++) mem[i] <= 32'd0;
  end
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr[6:0]] <= ram_wdata;
    ram_rdata <= mem[ram_addr[6:0]];
  end

  // Count write pulses and remember the write address
  always @(negedge clk) begin
    if (ram_we) begin
      we_cnt  = we_cnt + 1;
      we_addr = ram_addr;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One request: model computes fault/latency/data from the access rules, then DUT is compared
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd);
    int          idx;
    int          off;
    int          size;
    int          eoff;
    int          exp_lat;
    int          exp_we;
    int          lat;
    bit          legal;
    bit          mis;
    bit          exp_fault;
    logic [31:0] exp_rd;
    logic [31:0] w;
    idx   = int'(addr[31:2]);
    off   = int'(addr[1:0]);
    size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    legal = we ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)
               : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    mis   = legal && (off % size != 0);
    exp_fault = (addr[31:2] >= 30'(WORDS)) || !legal || (TRAP && mis);
    eoff  = off - (off % size);
    exp_rd = 32'd0;
    exp_we = 0;
    if (exp_fault) begin
      exp_lat = 1;
    end else if (we) begin
      exp_lat = (f3 == 3'd2) ? 2 : 3;
      exp_we  = 1;
      w = ref_mem[idx];
      for (int b = 0; b < size; b++) w[8*(eoff+b) +: 8] = wd[8*b +: 8];
      ref_mem[idx] = w;
    end else begin
      exp_lat = 2;
      w = ref_mem[idx] >> (8 * eoff);
      if (size == 1) begin
        exp_rd = w & 32'hFF;
        if (!f3[2] && exp_rd[7]) exp_rd = exp_rd | 32'hFFFF_FF00;
      end else if (size == 2) begin
        exp_rd = w & 32'hFFFF;
        if (!f3[2] && exp_rd[15]) exp_rd = exp_rd | 32'hFFFF_0000;
      end else begin
        exp_rd = w;
      end
    end

    @(negedge clk);
    check_eq("ready", {31'd0, req_ready}, 32'd1);
    we_cnt     = 0;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    lat = 1;
    while (!resp_valid && lat < 6) begin
      @(posedge clk);
      #1;
      lat++;
    end
    obs_rd = resp_rdata;
    check_eq("latency", lat, exp_lat);
    check_eq("rdata", resp_rdata, exp_rd);
    check_eq("fault", {31'd0, resp_fault}, {31'd0, exp_fault});
    @(posedge clk);
    #1;
    check_eq("valid_one_cycle", {31'd0, resp_valid}, 32'd0);
    check_eq("rdata_hold", resp_rdata, exp_rd);
    check_eq("fault_hold", {31'd0, resp_fault}, {31'd0, exp_fault});
    check_eq("we_pulses", we_cnt, exp_we);
    if (exp_we == 1) check_eq("we_addr", we_addr, idx);
  endtask

  initial begin
    int          bad;
    int          rv;
    n_tests    = 0;
    n_fail     = 0;
    we_cnt     = 0;
    we_addr    = 32'd0;
    obs_rd     = 32'd0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    for (int i = 0; i < WORDS; i++) ref_mem[i] = 32'd0;

    rst_n = 1'b0;
    #3;
    check_eq("rst_ready", {31'd0, req_ready}, 32'd1);
    check_eq("rst_valid", {31'd0, resp_valid}, 32'd0);
    check_eq("rst_rdata", resp_rdata, 32'd0);
    check_eq("rst_fault", {31'd0, resp_fault}, 32'd0);
    check_eq("rst_ram_we", {31'd0, ram_we}, 32'd0);
    check_eq("rst_ram_addr", ram_addr, 32'd0);
    check_eq("rst_ram_wdata", ram_wdata, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
    run_req(1'b0, 3'd2, 32'h10, 32'd0);
    check_eq("sw_lw_word4", obs_rd, 32'hDEADBEEF);
    run_req(1'b1, 3'd0, 32'h11, 32'h0000_0055);
    run_req(1'b0, 3'd2, 32'h10, 32'd0);
    check_eq("sb_merge", obs_rd, 32'hDEAD55EF);
    run_req(1'b0, 3'd0, 32'h11, 32'd0);
    check_eq("lb_11", obs_rd, 32'h0000_0055);
    run_req(1'b0, 3'd4, 32'h13, 32'd0);
    check_eq("lbu_13", obs_rd, 32'h0000_00DE);
    run_req(1'b0, 3'd0, 32'h13, 32'd0);
    check_eq("lb_13", obs_rd, 32'hFFFF_FFDE);
    run_req(1'b1, 3'd1, 32'h12, 32'h0000_8001);
    run_req(1'b0, 3'd1, 32'h12, 32'd0);
    check_eq("lh_12", obs_rd, 32'hFFFF_8001);
    run_req(1'b0, 3'd5, 32'h12, 32'd0);
    check_eq("lhu_12", obs_rd, 32'h0000_8001);
    run_req(1'b0, 3'd2, 32'h200, 32'd0);
    run_req(1'b1, 3'd2, 32'h12, 32'h1234_5678);
    run_req(1'b0, 3'd2, 32'h10, 32'd0);
    run_req(1'b0, 3'd3, 32'h10, 32'd0);
    run_req(1'b1, 3'd4, 32'h10, 32'h1);

    // Reset in the middle of the write cycle of a read-modify-write
    @(negedge clk);
    req_we     = 1'b1;
    req_funct3 = 3'd0;
    req_addr   = 32'h21;
    req_wdata  = 32'hA5;
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rmw_in_wr", {31'd0, ram_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_we", {31'd0, ram_we}, 32'd0);
    check_eq("rst_mid_ready", {31'd0, req_ready}, 32'd1);
    check_eq("rst_mid_valid", {31'd0, resp_valid}, 32'd0);
    rv = 0;
    repeat (2) begin
      @(negedge clk);
      if (resp_valid) rv++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) rv++;
    end
    check_eq("rst_no_resp", rv, 0);
    run_req(1'b0, 3'd2, 32'h20, 32'd0);
    check_eq("rst_no_write", obs_rd, 32'd0);

    for (int n = 0; n < 300; n++) begin
      run_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              {$urandom_range(0, WORDS + 7), 2'($urandom_range(0, 3))}, $urandom);
    end

    bad = 0;
    for (int i = 0; i < WORDS; i++) if (mem[i] !== ref_mem[i]) bad++;
    check_eq("ram_contents", bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
